// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered-output ALU between two requesters.
// Optional back-to-back accept during the response handshake: define ALU_ARB_B2B_EN.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_funct3,
    input  logic [6:0]        req0_funct7,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req0_sel,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_funct3,
    input  logic [6:0]        req1_funct7,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    input  logic              req1_sel,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,

    output logic [2:0]        alu_funct3,
    output logic [6:0]        alu_funct7,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_sel,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic last_grant;
    logic grant;
    logic accept_en;
    logic req_fire;
    logic cur_id;

    // With both requesting, serve the one not served last; otherwise whoever is asking.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        accept_en = 1'b0;
`ifdef ALU_ARB_B2B_EN
        accept_en = rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
`else
        accept_en = rst && (state == IDLE);
`endif
    end

    assign req0_ready = accept_en & req0_valid & ~grant;
    assign req1_ready = accept_en & req1_valid & grant;
    assign req_fire   = req0_ready | req1_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fire in RESP can only happen in the back-to-back build.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = req_fire ? ISSUE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_sel    <= 1'b0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (req_fire) begin
            alu_funct3 <= grant ? req1_funct3 : req0_funct3;
            alu_funct7 <= grant ? req1_funct7 : req0_funct7;
            alu_x      <= grant ? req1_x      : req0_x;
            alu_y      <= grant ? req1_y      : req0_y;
            alu_sel    <= grant ? req1_sel    : req0_sel;
            cur_id     <= grant;
            last_grant <= grant;
        end
    end

    // The ALU result is valid on alu_out during WAIT, one cycle after it sampled alu_*.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else if (state == WAIT) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_data  <= alu_out;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural one-cycle ALU.
// Expected intervals follow ALU_ARB_B2B_EN when it is defined for the build.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
`ifdef ALU_ARB_B2B_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0_valid = 1'b0;
    logic              req0_ready;
    logic [2:0]        req0_funct3 = '0;
    logic [6:0]        req0_funct7 = '0;
    logic [DATA_W-1:0] req0_x = '0;
    logic [DATA_W-1:0] req0_y = '0;
    logic              req0_sel = 1'b0;
    logic              req1_valid = 1'b0;
    logic              req1_ready;
    logic [2:0]        req1_funct3 = '0;
    logic [6:0]        req1_funct7 = '0;
    logic [DATA_W-1:0] req1_x = '0;
    logic [DATA_W-1:0] req1_y = '0;
    logic              req1_sel = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [2:0]        alu_funct3;
    logic [6:0]        alu_funct7;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_sel;
    logic [DATA_W-1:0] alu_out = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
        .req0_funct7(req0_funct7), .req0_x(req0_x), .req0_y(req0_y), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
        .req1_funct7(req1_funct7), .req1_x(req1_x), .req1_y(req1_y), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_x(alu_x), .alu_y(alu_y),
        .alu_sel(alu_sel), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shared ALU: registered result, one cycle after sampling its inputs.
    function automatic logic [DATA_W-1:0] aluModel(input logic [2:0] f3, input logic [6:0] f7,
                                                   input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                                   input logic sel);
        case (f3)
            3'b000:  return (!sel && f7[5]) ? x - y : x + y;
            3'b001:  return x << y[4:0];
            3'b100:  return x ^ y;
            3'b101:  return f7[5] ? DATA_W'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'b110:  return x | y;
            3'b111:  return x & y;
            3'b010:  return DATA_W'($signed(x) < $signed(y));
            default: return DATA_W'(x < y);
        endcase
    endfunction

    always @(posedge clk) alu_out <= aluModel(alu_funct3, alu_funct7, alu_x, alu_y, alu_sel);

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input logic v, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input logic sel);
        if (n == 0) begin
            req0_valid = v; req0_funct3 = f3; req0_funct7 = f7; req0_x = x; req0_y = y; req0_sel = sel;
        end else begin
            req1_valid = v; req1_funct3 = f3; req1_funct7 = f7; req1_x = x; req1_y = y; req1_sel = sel;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitReady(output logic id);
        int n;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 12) begin
            tick();
            n++;
        end
        if (n >= 12) checkOutput("ready_timeout", 32'd0, 32'd1);
        id = req1_ready;
    endtask

    task automatic waitResp();
        int n;
        n = 0;
        while (!rsp_valid && n < 12) begin
            tick();
            n++;
        end
        if (n >= 12) checkOutput("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic gid;
        int t1;
        int t2;

        // Reset held two edges, with a request pending that must not be granted.
        applyStimulus(0, 1'b1, 3'b000, 7'b0000000, 32'd5, 32'd7, 1'b0);
        tick();
        tick();
        checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_alu_xy", alu_x | alu_y, 32'd0);
        checkOutput("rst_alu_ctl", {22'd0, alu_funct3, alu_funct7, alu_sel}, 32'd0);

        // Single ADD 5+7 from req0.
        rst = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checkOutput("add_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("add_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        checkOutput("add_alu_x", alu_x, 32'd5);
        checkOutput("add_alu_y", alu_y, 32'd7);
        checkOutput("add_issue_valid", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("add_wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("add_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("add_rsp_data", rsp_data, 32'd12);
        checkOutput("add_rsp_id", 32'(rsp_id), 32'd0);
        tick();
        checkOutput("add_rsp_cleared", 32'(rsp_valid), 32'd0);

        // Fresh reset puts the pointer at 1; lone req1 must still be granted at once.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        applyStimulus(1, 1'b1, 3'b111, 7'b0000000, 32'hFF, 32'h0F, 1'b1);
        #1;
        checkOutput("solo_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("solo_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        checkOutput("andi_alu_x", alu_x, 32'hFF);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("midrst_alu_x", alu_x, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("midrst_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end

        // Tie fairness: both requesting continuously.
        applyStimulus(0, 1'b1, 3'b000, 7'b0100000, 32'd10, 32'd3, 1'b0);
        applyStimulus(1, 1'b1, 3'b100, 7'b0000000, 32'hF0, 32'h0F, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            waitReady(gid);
            checkOutput($sformatf("tie_grant%0d", k), 32'(gid), 32'(k % 2));
            checkOutput($sformatf("tie_onehot%0d", k), 32'(req0_ready & req1_ready), 32'd0);
            tick();
            waitResp();
            checkOutput($sformatf("tie_id%0d", k), 32'(rsp_id), 32'(k % 2));
            checkOutput($sformatf("tie_data%0d", k), rsp_data, (k % 2 == 0) ? 32'd7 : 32'hFF);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Response backpressure with req1 waiting behind an in-flight req0 op.
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, 3'b000, 7'b0000000, 32'd100, 32'd23, 1'b0);
        #1;
        checkOutput("bp_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        applyStimulus(1, 1'b1, 3'b110, 7'b0000000, 32'h3, 32'hC, 1'b0);
        waitResp();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_data%0d", i), rsp_data, 32'd123);
            checkOutput($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd0);
            checkOutput($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("bp_req1_ready%0d", i), 32'(req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(req1_ready), 32'(B2B));
        tick();
        checkOutput("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        if (B2B == 0) begin
            checkOutput("bp_idle_ready", 32'(req1_ready), 32'd1);
            tick();
        end
        req1_valid = 1'b0;
        waitResp();
        checkOutput("bp_or_data", rsp_data, 32'hF);
        checkOutput("bp_or_id", 32'(rsp_id), 32'd1);

        // Two queued req0 ADDs: response spacing is the initiation interval.
        applyStimulus(0, 1'b1, 3'b000, 7'b0000000, 32'd1, 32'd1, 1'b0);
        #1;
        waitReady(gid);
        tick();
        applyStimulus(0, 1'b1, 3'b000, 7'b0000000, 32'd2, 32'd2, 1'b0);
        waitResp();
        t1 = cyc;
        checkOutput("b2b_data0", rsp_data, 32'd2);
        waitReady(gid);
        tick();
        req0_valid = 1'b0;
        waitResp();
        t2 = cyc;
        checkOutput("b2b_data1", rsp_data, 32'd4);
        checkOutput("b2b_interval", 32'(t2 - t1), (B2B != 0) ? 32'd3 : 32'd4);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
